serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 24, operand and result width in bits.
REQ-002 Parameter DIGIT, default 4, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT, else elaboration SHALL fail.
REQ-003 Derived constant N = WIDTH/DIGIT, the number of digit cycles per operation.
REQ-004 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 RSTn  in  1  reset; asynchronous, active-low.
REQ-006 IN_VALID  in  1  operands and mode valid.
REQ-007 IN_READY  out  1  block can accept an operation.
REQ-008 A  in  WIDTH  operand A, two's complement or unsigned.
REQ-009 B  in  WIDTH  operand B.
REQ-010 SUB  in  1  0 = A+B, 1 = A-B; sampled with the operands.
REQ-011 OUT_VALID  out  1  result valid.
REQ-012 OUT_READY  in  1  consumer accepts result.
REQ-013 S  out  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 COUT  out  1  carry out of MSB; for SUB, 1 = no borrow (A >= B unsigned).
REQ-015 OVF  out  1  signed overflow (carry into MSB XOR carry out of MSB).
REQ-016 BUSY  out  1  high in RUN and DONE.

Function
REQ-017 FSM states IDLE, RUN, DONE; IN_READY = 1 only in IDLE; OUT_VALID = 1 only in DONE.
REQ-018 IDLE: on IN_VALID & IN_READY at an edge, latch A, latch B (bitwise inverted if SUB = 1), set carry = SUB, clear digit counter, go to RUN.
REQ-019 IDLE with IN_VALID = 0: stay in IDLE; input values ignored.
REQ-020 RUN: each cycle add the current DIGIT-bit slice (LSB slice first) of latched A and B plus the carry register; store the DIGIT-bit sum into the corresponding slice of S; update the carry register; increment the counter.
REQ-021 The slice at counter value N-1 SHALL set COUT = final carry, set OVF = carry into bit WIDTH-1 XOR final carry, and transition to DONE.
REQ-022 Latency: if accept occurs at edge t, OUT_VALID SHALL first be high after edge t+N; DIGIT = WIDTH gives a one-cycle latency.
REQ-023 DONE: S, COUT, OVF SHALL stay stable while OUT_VALID = 1 and OUT_READY = 0 (backpressure held indefinitely).
REQ-024 DONE with OUT_READY = 1 at an edge: go to IDLE; IN_READY SHALL be high in the following cycle; no same-cycle accept from DONE.
REQ-025 Operand inputs, SUB, and IN_VALID SHALL be ignored in RUN and DONE; changing them mid-operation SHALL NOT affect the result.
REQ-026 S, COUT, OVF are checked only while OUT_VALID = 1; outside DONE they hold their previous or partial values.
REQ-027 Counter width SHALL be ceil(log2(N)), minimum 1 bit; the counter SHALL NOT wrap within an operation.

Reset
REQ-028 RSTn low SHALL asynchronously force IDLE, counter = 0, carry = 0, S = 0, COUT = 0, OVF = 0, OUT_VALID = 0, BUSY = 0, and IN_READY = 1 while RSTn is low and after release.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation; no OUT_VALID pulse for the aborted operation SHALL follow.
REQ-030 The first accept after reset release SHALL occur no earlier than the first rising edge with RSTn high.

Verification (WIDTH=8, DIGIT=4 unless noted)
REQ-031 A=0x3C, B=0x15, SUB=0, OUT_READY=1 -> OUT_VALID two cycles after accept; S=0x51, COUT=0, OVF=0; IN_READY high on the next cycle.
REQ-032 A=0x7F, B=0x01, SUB=0 -> S=0x80, COUT=0, OVF=1; A=0xFF, B=0x01 -> S=0x00, COUT=1, OVF=0.
REQ-033 A=0x05, B=0x07, SUB=1 -> S=0xFE, COUT=0, OVF=0; A=0x80, B=0x01, SUB=1 -> S=0x7F, COUT=1, OVF=1.
REQ-034 OUT_READY held 0 for 5 cycles in DONE, with A/B toggled and IN_VALID=1 throughout -> S, COUT, OVF, and OUT_VALID stable; IN_READY=0; result delivered when OUT_READY=1.
REQ-035 RSTn pulsed low during RUN (after the first digit) -> all outputs at reset values immediately; no OUT_VALID; a next operation 0x10+0x20 gives S=0x30.
REQ-036 WIDTH=DIGIT=8 and WIDTH=24/DIGIT=1: random operands with both SUB values -> results match the reference model; latency is 1 and 24 cycles respectively.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor with valid/ready handshakes.
// Each operation takes WIDTH/DIGIT cycles. Each cycle adds one DIGIT-bit slice,
// starting with the least significant slice, and a single carry bit links the
// slices.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a, b, sub are valid
//   in_ready   block is idle and can accept an operation
//   a, b       operands (unsigned or two's complement)
//   sub        0: a+b, 1: a-b (sampled at accept)
//   out_valid  s, cout, ovf hold the finished result
//   out_ready  consumer takes the result
//   s          sum/difference modulo 2^WIDTH
//   cout       carry out of the MSB (for sub: 1 = no borrow)
//   ovf        signed overflow
//   busy       operation in progress or result waiting
//
// state | meaning
// IDLE  | waiting for in_valid; operands are latched on accept
// RUN   | adding one digit per cycle
// DONE  | result presented; held until out_ready
module serial_adder #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
      $error("serial_adder: WIDTH must be an integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  // Operands shift right by one digit per RUN cycle, so the working digit is
  // always in the low slice of each register.
  logic [WIDTH-1:0]       a_q, b_q;
  logic                   carry_q;
  logic [CW-1:0]          cnt_q;
  logic [DIGIT-1:0]       a_dig, b_dig;
  logic [DIGIT:0]         dig_sum;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic                   last_dig;

  assign a_dig    = a_q[DIGIT-1:0];
  assign b_dig    = b_q[DIGIT-1:0];
  assign dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
  assign last_dig = (cnt_q == LAST);
  // New digit enters at the top. After N shifts, the first digit sits in the
  // low slice.
  assign s_cat    = {dig_sum[DIGIT-1:0], s};

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_dig) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s       <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= dig_sum[DIGIT];
          s       <= s_cat[WIDTH+DIGIT-1:DIGIT];
          if (last_dig) begin
            cout <= dig_sum[DIGIT];
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            ovf  <= a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1] ^ dig_sum[DIGIT];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder. It instantiates three configurations: 8/4
// (directed vectors), 8/8, and 24/1 (model-checked random operands).
// A driver pushes the expected result for each accepted operation into a
// per-instance queue. A monitor compares every cycle in which out_valid is high.
module tb_serial_adder;

  typedef struct packed {
    logic [23:0] s;
    logic        c;
    logic        o;
    logic [31:0] acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  iv = 3'b000;
  logic [2:0]  orr = 3'b111;
  logic [2:0]  subv = 3'b000;
  logic [23:0] av [3];
  logic [23:0] bv [3];
  wire  [2:0]  ir, ov, co, of, bz;
  wire  [7:0]  s0, s1;
  wire  [23:0] s2;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q [3][$];
  logic [2:0] pov = 3'b000;
  logic [2:0] rdy_chk = 3'b000;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0][7:0]), .b(bv[0][7:0]), .sub(subv[0]), .out_valid(ov[0]),
    .out_ready(orr[0]), .s(s0), .cout(co[0]), .ovf(of[0]), .busy(bz[0]));

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1][7:0]), .b(bv[1][7:0]), .sub(subv[1]), .out_valid(ov[1]),
    .out_ready(orr[1]), .s(s1), .cout(co[1]), .ovf(of[1]), .busy(bz[1]));

  serial_adder #(.WIDTH(24), .DIGIT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(av[2]), .b(bv[2]), .sub(subv[2]), .out_valid(ov[2]),
    .out_ready(orr[2]), .s(s2), .cout(co[2]), .ovf(of[2]), .busy(bz[2]));

  function automatic logic [23:0] sget(input int k);
    case (k)
      0:       return {16'd0, s0};
      1:       return {16'd0, s1};
      default: return s2;
    endcase
  endfunction

  function automatic int nlat(input int k);
    case (k)
      0:       return 2;
      1:       return 1;
      default: return 24;
    endcase
  endfunction

  function automatic int wid(input int k);
    return (k == 2) ? 24 : 8;
  endfunction

  // Reference: full-width addition, then signed overflow from operand and result signs.
  function automatic exp_t model(input int w, input logic [23:0] a, input logic [23:0] b,
                                 input logic sb);
    exp_t        e;
    logic [23:0] mask, aa, bb;
    logic [24:0] full;
    logic [4:0]  m, wi;
    mask  = 24'hFFFFFF >> (24 - w);
    aa    = a & mask;
    bb    = (sb ? ~b : b) & mask;
    full  = {1'b0, aa} + {1'b0, bb} + {24'd0, sb};
    m     = 5'(w - 1);
    wi    = 5'(w);
    e.s   = full[23:0] & mask;
    e.c   = full[wi];
    e.o   = (aa[m] == bb[m]) && (e.s[m] != aa[m]);
    e.acc = '0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Call at posedge+#1; returns at posedge+#1 after the accept edge.
  task automatic issue(input int k, input logic [23:0] a, input logic [23:0] b, input logic sb,
                       input bit push, input logic [23:0] es, input logic ec, input logic eo);
    int g = 0;
    while (!ir[k] && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!ir[k]) chk($sformatf("d%0d_wait_in_ready", k), {31'd0, ir[k]}, 32'd1);
    av[k]   = a;
    bv[k]   = b;
    subv[k] = sb;
    iv[k]   = 1'b1;
    @(posedge clk); #1;
    if (push) q[k].push_back('{es, ec, eo, 32'(cyc)});
    iv[k] = 1'b0;
  endtask

  task automatic rnd_op(input int k, input logic sb);
    exp_t        e;
    logic [23:0] a, b;
    a = 24'($urandom);
    b = 24'($urandom);
    e = model(wid(k), a, b, sb);
    issue(k, a, b, sb, 1'b1, e.s, e.c, e.o);
  endtask

  task automatic wait_drain(input int k);
    int g = 0;
    while ((q[k].size() != 0 || !ir[k]) && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (q[k].size() != 0) chk($sformatf("d%0d_drain_timeout", k), 32'(q[k].size()), 32'd0);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_in_ready"},  {31'd0, ir[0]}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, ov[0]}, 32'd0);
    chk({tag, "_busy"},      {31'd0, bz[0]}, 32'd0);
    chk({tag, "_s"},         {24'd0, s0},    32'd0);
    chk({tag, "_cout"},      {31'd0, co[0]}, 32'd0);
    chk({tag, "_ovf"},       {31'd0, of[0]}, 32'd0);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy_chk[k]) chk($sformatf("d%0d_in_ready_after_done", k), {31'd0, ir[k]}, 32'd1);
      rdy_chk[k] <= 1'b0;
      if (ov[k]) begin
        if (q[k].size() == 0) begin
          chk($sformatf("d%0d_unexpected_out_valid", k), {31'd0, ov[k]}, 32'd0);
        end else begin
          chk($sformatf("d%0d_s", k),    {8'd0, sget(k)}, {8'd0, q[k][0].s});
          chk($sformatf("d%0d_cout", k), {31'd0, co[k]},  {31'd0, q[k][0].c});
          chk($sformatf("d%0d_ovf", k),  {31'd0, of[k]},  {31'd0, q[k][0].o});
          chk($sformatf("d%0d_in_ready_low", k), {31'd0, ir[k]}, 32'd0);
          chk($sformatf("d%0d_busy_high", k),    {31'd0, bz[k]}, 32'd1);
          if (!pov[k]) chk($sformatf("d%0d_latency", k), 32'(cyc) - q[k][0].acc, 32'(nlat(k)));
          if (orr[k]) begin
            void'(q[k].pop_front());
            rdy_chk[k] <= 1'b1;
          end
        end
      end
    end
    pov <= ov;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      av[k] = '0;
      bv[k] = '0;
    end
    #2;
    chk_reset0("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_reset0("post_reset");

    // Directed 8-bit vectors (dut0, WIDTH=8 DIGIT=4).
    issue(0, 24'h3C, 24'h15, 1'b0, 1'b1, 24'h51, 1'b0, 1'b0);
    issue(0, 24'h7F, 24'h01, 1'b0, 1'b1, 24'h80, 1'b0, 1'b1);
    issue(0, 24'hFF, 24'h01, 1'b0, 1'b1, 24'h00, 1'b1, 1'b0);
    issue(0, 24'h05, 24'h07, 1'b1, 1'b1, 24'hFE, 1'b0, 1'b0);
    issue(0, 24'h80, 24'h01, 1'b1, 1'b1, 24'h7F, 1'b1, 1'b1);
    issue(0, 24'h00, 24'h00, 1'b1, 1'b1, 24'h00, 1'b1, 1'b0);
    issue(0, 24'h80, 24'h80, 1'b0, 1'b1, 24'h00, 1'b1, 1'b1);
    issue(0, 24'h7F, 24'hFF, 1'b1, 1'b1, 24'h80, 1'b0, 1'b1);
    wait_drain(0);

    // Backpressure: result held for 5 DONE cycles while inputs churn.
    orr[0]  = 1'b0;
    av[0]   = 24'hA5;
    bv[0]   = 24'h3C;
    subv[0] = 1'b0;
    iv[0]   = 1'b1;
    @(posedge clk); #1;
    q[0].push_back('{24'hE1, 1'b0, 1'b0, 32'(cyc)});
    repeat (7) begin
      av[0]   = ~av[0];
      bv[0]   = 24'($urandom);
      subv[0] = ~subv[0];
      @(posedge clk); #1;
    end
    orr[0] = 1'b1;
    iv[0]  = 1'b0;
    wait_drain(0);

    // Reset during RUN after the first digit: aborted, no result may appear.
    issue(0, 24'h11, 24'h22, 1'b0, 1'b0, 24'h00, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset0("abort_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    issue(0, 24'h10, 24'h20, 1'b0, 1'b1, 24'h30, 1'b0, 1'b0);
    wait_drain(0);

    // Single-cycle and bit-serial configurations against the model.
    for (int i = 0; i < 8; i++) rnd_op(1, i[0]);
    wait_drain(1);
    for (int i = 0; i < 8; i++) rnd_op(2, i[0]);
    wait_drain(2);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
